// File: rtl/byte_word_packer_if.sv
// Byte-stream-in / packed-word-out bundle for byte_word_packer.
// The master modport is the upstream byte source; the slave modport is the packer.
interface byte_word_packer_if #(
  parameter int NBYTES = 4,
  parameter int BW     = 8
);
  localparam int W  = NBYTES * BW;
  localparam int IW = $clog2(NBYTES + 1);

  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          in_last;
  logic [W-1:0]  word_out;
  logic          word_load;
  logic [IW-1:0] word_bytes;
  logic          short_frame;
  logic          timeout;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, word_out, word_load, word_bytes, short_frame, timeout
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, word_out, word_load, word_bytes, short_frame, timeout
  );
endinterface

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into NBYTES*BW words and strobes each word for one cycle.
// Optional idle-timeout flush of partial words is enabled by defining PACK_TIMEOUT_EN.
module byte_word_packer #(
  parameter int NBYTES    = 4,
  parameter int BW        = 8,
  parameter int TO_CYCLES = 16
) (
  input  logic              clk,
  input  logic              clear,
  byte_word_packer_if.slave bus
);
  localparam int W  = NBYTES * BW;
  localparam int IW = $clog2(NBYTES + 1);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t        state_r;
  logic [W-1:0]  acc_r;
  logic [W-1:0]  acc_s;
  logic [W-1:0]  word_r;
  logic [IW-1:0] idx_r;
  logic [IW-1:0] bytes_r;
  logic          load_r;
  logic          short_r;
  logic          tout_r;
  logic          accept_s;
  logic          last_slot_s;
  logic          close_s;
  logic          to_fire_s;

  assign accept_s    = bus.in_valid & (state_r == FILL);
  assign last_slot_s = (idx_r == IW'(NBYTES - 1));
  assign close_s     = accept_s & (last_slot_s | bus.in_last);

  // Accumulator with the incoming byte merged at the current slot
  always_comb begin
    acc_s = acc_r;
    acc_s[int'(idx_r) * BW +: BW] = bus.in_data;
  end

`ifdef PACK_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0] idle_r;
  logic          idling_s;

  assign idling_s  = (state_r == FILL) & (idx_r != IW'(0)) & ~bus.in_valid;
  assign to_fire_s = idling_s & (idle_r == CW'(TO_CYCLES - 1));

  // Idle counter: runs only while a partial word waits without new bytes
  always_ff @(posedge clk) begin
    if (clear) begin
      idle_r <= CW'(0);
    end else if (idling_s && !to_fire_s) begin
      idle_r <= idle_r + CW'(1);
    end else begin
      idle_r <= CW'(0);
    end
  end
`else
  assign to_fire_s = 1'b0;
`endif

  // Packer FSM; all outputs are registered and hold until the next issued word
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r <= FILL;
      acc_r   <= W'(0);
      idx_r   <= IW'(0);
      word_r  <= W'(0);
      bytes_r <= IW'(0);
      load_r  <= 1'b0;
      short_r <= 1'b0;
      tout_r  <= 1'b0;
    end else begin
      load_r <= 1'b0;
      case (state_r)
        FILL: begin
          if (close_s) begin
            // Unfilled slots are already zero because the accumulator clears per word
            state_r <= ISSUE;
            word_r  <= acc_s;
            bytes_r <= idx_r + IW'(1);
            short_r <= ~last_slot_s;
            tout_r  <= 1'b0;
            load_r  <= 1'b1;
            acc_r   <= W'(0);
            idx_r   <= IW'(0);
          end else if (accept_s) begin
            acc_r <= acc_s;
            idx_r <= idx_r + IW'(1);
          end else if (to_fire_s) begin
            state_r <= ISSUE;
            word_r  <= acc_r;
            bytes_r <= idx_r;
            short_r <= 1'b0;
            tout_r  <= 1'b1;
            load_r  <= 1'b1;
            acc_r   <= W'(0);
            idx_r   <= IW'(0);
          end else begin
            state_r <= FILL;
          end
        end
        ISSUE: begin
          state_r <= FILL;
        end
        default: begin
          state_r <= FILL;
        end
      endcase
    end
  end

  assign bus.in_ready    = (state_r == FILL);
  assign bus.word_out    = word_r;
  assign bus.word_load   = load_r;
  assign bus.word_bytes  = bytes_r;
  assign bus.short_frame = short_r;
  assign bus.timeout     = tout_r;
endmodule

// File: tb/tb_byte_word_packer.sv
// Bench for byte_word_packer: directed scenarios plus random traffic against a queue-based frame model.
// Builds with or without PACK_TIMEOUT_EN; the model follows the same macro.
module tb_byte_word_packer;
  localparam int NBYTES = 4;
  localparam int BW     = 8;
  localparam int TO     = 16;
`ifdef PACK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic clear;
  int   checks;
  int   errors;

  byte_word_packer_if #(.NBYTES(NBYTES), .BW(BW)) bus ();

  byte_word_packer #(.NBYTES(NBYTES), .BW(BW), .TO_CYCLES(TO)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the bytes of the frame in progress, plus the last issued word
  logic [7:0]  q[$];
  int          idle;
  logic        m_load;
  logic        m_ready;
  logic [31:0] m_word;
  int          m_bytes;
  logic        m_short;
  logic        m_tout;
  int          dut_loads;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic close_word(input logic by_timeout);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < q.size(); i++) w = w + (32'(q[i]) << (8 * i));
    m_word  = w;
    m_bytes = q.size();
    m_short = !by_timeout && (q.size() < NBYTES);
    m_tout  = by_timeout;
    m_load  = 1'b1;
    q.delete();
    idle = 0;
  endtask

  // Drive one cycle, advance the model across the edge, then compare just after the edge
  task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic c);
    logic acc;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    clear        = c;
    @(posedge clk);
    acc = v && m_ready;
    if (c) begin
      q.delete();
      idle = 0; m_load = 1'b0; m_word = 32'h0; m_bytes = 0; m_short = 1'b0; m_tout = 1'b0;
    end else if (m_load) begin
      m_load = 1'b0;
    end else if (acc) begin
      q.push_back(d);
      idle = 0;
      if (q.size() == NBYTES || l) close_word(1'b0);
    end else if (TO_EN && q.size() > 0) begin
      idle++;
      if (idle == TO) close_word(1'b1);
    end
    m_ready = !m_load;
    #1;
    if (bus.word_load === 1'b1) dut_loads++;
    chk("word_load",   64'(bus.word_load),   64'(m_load));
    chk("in_ready",    64'(bus.in_ready),    64'(m_ready));
    chk("word_out",    64'(bus.word_out),    64'(m_word));
    chk("word_bytes",  64'(bus.word_bytes),  64'(m_bytes));
    chk("short_frame", 64'(bus.short_frame), 64'(m_short));
    chk("timeout",     64'(bus.timeout),     64'(m_tout));
  endtask

  initial begin
    int k;
    int base;
    logic r;
    checks = 0; errors = 0; dut_loads = 0; idle = 0;
    m_load = 1'b0; m_ready = 1'b1; m_word = 32'h0; m_bytes = 0; m_short = 1'b0; m_tout = 1'b0;
    clear = 1'b1; bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;

    // 1: reset state
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("rst_word", 64'(bus.word_out), 64'h0);
    chk("rst_ready", 64'(bus.in_ready), 64'h1);

    // 2: full word
    cyc(1'b1, 8'h78, 1'b0, 1'b0);
    cyc(1'b1, 8'h56, 1'b0, 1'b0);
    cyc(1'b1, 8'h34, 1'b0, 1'b0);
    cyc(1'b1, 8'h12, 1'b0, 1'b0);
    chk("t2_load", 64'(bus.word_load), 64'h1);
    chk("t2_word", 64'(bus.word_out), 64'h12345678);
    chk("t2_bytes", 64'(bus.word_bytes), 64'h4);
    chk("t2_short", 64'(bus.short_frame), 64'h0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t2_hold", 64'(bus.word_out), 64'h12345678);

    // 3: short frame
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    cyc(1'b1, 8'hBB, 1'b1, 1'b0);
    chk("t3_word", 64'(bus.word_out), 64'h0000BBAA);
    chk("t3_bytes", 64'(bus.word_bytes), 64'h2);
    chk("t3_short", 64'(bus.short_frame), 64'h1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // 4: valid held through the ISSUE bubble; byte 05 starts the next word
    k = 0;
    for (int n = 0; n < 12 && k < 8; n++) begin
      r = m_ready;
      cyc(1'b1, 8'(k + 1), 1'b0, 1'b0);
      if (bus.word_load === 1'b1 && k == 3) begin
        chk("t4_word1", 64'(bus.word_out), 64'h04030201);
        chk("t4_ready", 64'(bus.in_ready), 64'h0);
      end
      if (r) k++;
    end
    chk("t4_word2", 64'(bus.word_out), 64'h08070605);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // 5: clear mid-word discards the partial word
    base = dut_loads;
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h44, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    chk("t5_word", 64'(bus.word_out), 64'h11223344);
    for (int n = 0; n < 4; n++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_loads", 64'(dut_loads - base), 64'h1);

    // 6: lone byte followed by idle cycles
    base = dut_loads;
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    if (TO_EN) begin
      for (int n = 0; n < TO; n++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("t6_load", 64'(bus.word_load), 64'h1);
      chk("t6_word", 64'(bus.word_out), 64'h0000005A);
      chk("t6_bytes", 64'(bus.word_bytes), 64'h1);
      chk("t6_tout", 64'(bus.timeout), 64'h1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
    end else begin
      for (int n = 0; n < 100; n++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("t6_noload", 64'(dut_loads - base), 64'h0);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic: valid gaps, early last, occasional clear, long idle bursts
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        for (int j = 0; j < 18; j++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
      end else begin
        cyc($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 4) == 0,
            $urandom_range(0, 59) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
